ps2_rx: RTL and testbench

- Receiver for the PS/2-style serial link: the device drives `ps2_clk`/`ps2_dat`, and this block reassembles 11-bit frames into bytes.
- Frame format:
  - line idles high on both wires;
  - start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1;
  - the device changes `ps2_dat` while `ps2_clk` is high, and the receiver samples on the `ps2_clk` falling edge.
- Sits between the external pins and the keycode consumer, which uses a valid/ready interface.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_rx.sv | 130 +++++++++++++
 tb/tb_ps2_rx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM states, frame geometry and the
// odd-parity helper used by both the design and its frame generator.
package ps2_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Parity bit that makes the nine bits (byte + parity) contain an odd number of ones.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pin conditioner: multi-flop synchronizer, run-length glitch filter and a
// registered one-cycle strobe on each filtered high-to-low transition.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic filt,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          run_cnt;
    logic                   din_s;

    assign din_s = sync_q[SYNC_STAGES-1];

    // NOTE: every register here uses non-blocking assignment so all flops see
    // the pre-edge values of each other; blocking would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Count consecutive samples that disagree with the filtered level; flip once
    // the run reaches FILTER_LEN, and restart the run on any agreeing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt    <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (din_s != filt) begin
                if (run_cnt == CW'(FILTER_LEN - 1)) begin
                    filt    <= din_s;
                    run_cnt <= '0;
                    fall    <= filt;
                end else begin
                    run_cnt <= run_cnt + CW'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: conditions the device clock/data pins, reassembles 11-bit
// frames into bytes and hands them to a valid/ready consumer.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DATA_BITS);

    logic                   clk_filt;
    logic                   fall;
    logic                   unused_filt;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   dat_s;

    state_t                 state;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic [TW-1:0]          to_cnt;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_clk),
        .filt (clk_filt),
        .fall (fall)
    );

    assign unused_filt = clk_filt;

    // Data is only looked at on a filtered clock fall, long after it settled,
    // so a plain synchronizer is enough here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_sync <= '1;
        end else begin
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
        end
    end

    assign dat_s = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (fall) begin
                // A fall always wins over a coinciding timeout.
                to_cnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!dat_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!dat_s) begin
                            frame_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            rx_data    <= shreg;
                            parity_err <= (par_bit != odd_parity(shreg));
                            rx_valid   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: a frame-level model predicts deliveries,
// frame errors and overruns; a per-cycle monitor checks the consumer side.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int S  = 2;
    localparam int FL = 4;
    localparam int TO = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    ps2_rx #(
        .SYNC_STAGES    (S),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #500 clk = ~clk;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } item_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    item_t exp_q[$];
    item_t e;
    int    exp_ferr = 0, exp_ovr = 0;
    int    obs_ferr = 0, obs_ovr = 0;
    int    last_fall_cyc = 0, ferr_cyc = 0;
    logic       prev_valid = 1'b0, prev_xfer = 1'b0, prev_perr = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Consumer-side monitor: every transfer must match the next predicted byte,
    // and a held byte must not change until it is taken.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (frame_err === 1'b1) begin
                obs_ferr++;
                ferr_cyc = cyc;
            end
            if (overrun === 1'b1) obs_ovr++;
            if (rx_valid && prev_valid && !prev_xfer)
                check("hold_stable", {23'd0, parity_err, rx_data}, {23'd0, prev_perr, prev_data});
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer: got 0x%0h, expected no transfer", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_data", {24'd0, rx_data}, {24'd0, e.data});
                    check("xfer_perr", {31'd0, parity_err}, {31'd0, e.perr});
                end
            end
            prev_valid = rx_valid;
            prev_xfer  = rx_valid & rx_ready;
            prev_data  = rx_data;
            prev_perr  = parity_err;
        end
    end

    // Frame-level model: bad stop -> frame error; a good frame is dropped with
    // an overrun only if a byte is still held and the consumer is not ready.
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input bit ready_at_delivery);
        if (bad_stop) exp_ferr++;
        else if (exp_q.size() != 0 && !ready_at_delivery) exp_ovr++;
        else exp_q.push_back(item_t'{perr: bad_par, data: b});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int hp, input int nbits, input bit raise_ready);
        logic [10:0] f;
        f = {~bad_stop, odd_parity(b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            wait_cyc(hp / 2);
            ps2_dat = f[i];
            wait_cyc(hp - hp / 2);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (raise_ready && i == FRAME_BITS - 1) begin
                // Raise ready in the cycle the stop-bit fall is being acted on.
                repeat (S + FL) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(negedge clk);
                wait_cyc(hp - (S + FL));
            end else begin
                wait_cyc(hp);
            end
            ps2_clk = 1'b1;
        end
        wait_cyc(hp / 2);
        ps2_dat = 1'b1;
        wait_cyc(hp);
    endtask

    task automatic check_counts(input string name);
        check({name, "_ferr"}, obs_ferr, exp_ferr);
        check({name, "_ovr"}, obs_ovr, exp_ovr);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, {31'd0, rx_valid}, 0);
        check({name, "_data"}, {24'd0, rx_data}, 0);
        check({name, "_perr"}, {31'd0, parity_err}, 0);
        check({name, "_ferr_pin"}, {31'd0, frame_err}, 0);
        check({name, "_ovr_pin"}, {31'd0, overrun}, 0);
    endtask

    initial begin
        int base;
        int lat;
        logic [7:0] b;
        bit bp, bs, r;
        int hp;

        ps2_clk  = 1'b1;
        ps2_dat  = 1'b1;
        rx_ready = 1'b0;
        rst      = 1'b1;
        wait_cyc(5);
        check_outputs_zero("reset");
        rst = 1'b0;

        check("odd_parity_00", {31'd0, odd_parity(8'h00)}, 1);
        check("odd_parity_07", {31'd0, odd_parity(8'h07)}, 0);
        check("odd_parity_a5", {31'd0, odd_parity(8'hA5)}, 1);

        set_ready(1'b1);
        for (int i = 0; i < 16; i++) begin
            model_frame(8'(i), 1'b0, 1'b0, 1'b1);
            send_frame(8'(i), 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        end
        check_counts("seq");

        set_ready(1'b0);
        model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 40, FRAME_BITS, 1'b0);
        check("bad_par_valid", {31'd0, rx_valid}, 1);
        check("bad_par_data", {24'd0, rx_data}, 32'hA5);
        check("bad_par_flag", {31'd0, parity_err}, 1);
        set_ready(1'b1);
        wait_cyc(3);
        check_counts("bad_par");

        base = obs_ferr;
        model_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 40, FRAME_BITS, 1'b0);
        check("bad_stop_pulses", obs_ferr - base, 1);
        model_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        check_counts("bad_stop");

        base = obs_ferr;
        exp_ferr++;
        send_frame(8'h96, 1'b0, 1'b0, 40, 5, 1'b0);
        wait_cyc(2500 - (cyc - last_fall_cyc));
        check("timeout_pulses", obs_ferr - base, 1);
        lat = ferr_cyc - last_fall_cyc;
        check("timeout_latency_ok", {31'd0, (lat >= TO + S + FL) && (lat <= TO + S + FL + 2)}, 1);
        model_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        check_counts("timeout");

        base = obs_ovr;
        set_ready(1'b0);
        model_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        model_frame(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        check("ovr_held_data", {24'd0, rx_data}, 32'h11);
        check("ovr_held_valid", {31'd0, rx_valid}, 1);
        check("ovr_pulses", obs_ovr - base, 1);
        model_frame(8'h33, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b0, 40, FRAME_BITS, 1'b1);
        check("ovr_no_second", obs_ovr - base, 1);
        check_counts("overrun");

        base = obs_ferr;
        @(negedge clk);
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(2);
        ps2_dat = 1'b1;
        wait_cyc(2500);
        check("glitch_no_ferr", obs_ferr - base, 0);
        model_frame(8'h42, 1'b0, 1'b0, 1'b1);
        send_frame(8'h42, 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        check_counts("glitch");

        set_ready(1'b0);
        model_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        check("pre_rst_valid", {31'd0, rx_valid}, 1);
        send_frame(8'h0F, 1'b0, 1'b0, 40, 6, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(3);
        check_outputs_zero("mid_rst");
        exp_q.delete();
        rst = 1'b0;
        set_ready(1'b1);
        model_frame(8'h77, 1'b0, 1'b0, 1'b1);
        send_frame(8'h77, 1'b0, 1'b0, 40, FRAME_BITS, 1'b0);
        check_counts("after_rst");

        for (int i = 0; i < 16; i++) begin
            b  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 5) == 0);
            hp = $urandom_range(30, 45);
            r  = ($urandom_range(0, 3) != 0);
            set_ready(r);
            wait_cyc(2);
            model_frame(b, bp, bs, r);
            send_frame(b, bp, bs, hp, FRAME_BITS, 1'b0);
        end
        set_ready(1'b1);
        wait_cyc(10);
        check_counts("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
